gray_ptr_counter: RTL
=====================

Name: gray_ptr_counter

Overview:
Registered binary-to-Gray pointer counter, the encode direction of the team's gray-to-binary decoder.
Keeps a binary count and drives its Gray-coded image from flops, so the Gray bus changes at most one bit per count step.
Used as the read/write pointer source for async FIFOs and other clock-domain-crossing pointers.
The Gray output is safe to synchronise into another domain without glitch filtering.

Parameters:
WIDTH, 4, pointer width in bits (>=2); count range 0 .. 2^WIDTH-1

Ports:
clk       input   1      rising-edge clock
rst       input   1      asynchronous, active-high reset
clr       input   1      synchronous clear to zero
load      input   1      synchronous load of load_bin
load_bin  input   WIDTH  binary value applied when load=1
inc       input   1      count-step enable
dir       input   1      step direction: 1=up, 0=down; sampled only when inc=1
bin       output  WIDTH  registered binary count
gray      output  WIDTH  registered Gray code of bin
gray_nxt  output  WIDTH  combinational Gray code of the next-state binary value
wrap      output  1      registered one-cycle pulse on count wrap

Behaviour:
- Reset (asynchronous, active-high) immediately forces bin=0, gray=0 and wrap=0. The block holds these values while rst=1.
- First rising clk edge after rst deasserts evaluates inputs normally.
- Per-edge priority: clr > load > inc > hold.
  - clr=1: bin_n=0.
  - else load=1: bin_n=load_bin.
  - else inc=1, dir=1: bin_n=bin+1 mod 2^WIDTH.
  - else inc=1, dir=0: bin_n=bin-1 mod 2^WIDTH.
  - else bin_n=bin.
- Gray encoding: gray_nxt = bin_n ^ (bin_n >> 1), logical shift with MSB fill 0. gray_nxt[WIDTH-1]=bin_n[WIDTH-1].
- gray register loads gray_nxt on the same edge that bin loads bin_n.
- gray is never derived from the registered bin through logic after the flops. No combinational path reaches the gray output pins.
- Latency: bin and gray both reflect a request exactly 1 cycle after the sampling edge. They are always mutually consistent: gray == bin ^ (bin>>1) every cycle.
- Single-bit property: when the update comes only from inc (no clr/load), gray differs from its previous value in exactly one bit. Hold changes zero bits.
- clr and load may change multiple Gray bits. The CDC user must qualify these; the block does no qualification.
- wrap:
  - Set to 1 for exactly one cycle when an inc step goes up from all-ones to 0, or down from 0 to all-ones.
  - 0 otherwise, including on clr or load, even when the loaded value looks like a wrap.
- Simultaneous events:
  - clr with load/inc gives 0 and wrap=0.
  - load with inc gives load_bin; the inc is dropped.
  - dir is ignored when inc=0.
- Reset mid-operation: asynchronous clear of all flops, with any in-flight step discarded. No recovery state.
- No X propagation: with X on dir while inc=0, outputs must hold.

Test Plan:
- Up count (WIDTH=4): reset, then inc=1 dir=1 for 16 cycles.
  - gray sequence must be 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - bin steps 0..F,0.
  - wrap=1 only in the cycle where bin returns to 0.
- Down count: from reset, a single inc=1 dir=0 step.
  - Required: bin=F, gray=8, wrap=1 for one cycle.
  - A second down step gives bin=E, gray=9, wrap=0.
- Load/priority:
  - load=1, load_bin=A → bin=A, gray=F, wrap=0.
  - Next cycle, load=1 with inc=1 and load_bin=3 → bin=3, gray=2.
  - Next, clr=1 with load=1 and inc=1 → bin=0, gray=0.
- Reset mid-count: count up to bin=6 (gray=5), then assert rst asynchronously between edges.
  - bin, gray and wrap must read 0 before the next edge.
  - Release rst, then one inc → bin=1, gray=1.
- Random property run: 10k cycles of random clr/load/inc/dir.
  - Every cycle, gray == bin ^ (bin>>1).
  - Hamming distance of gray between consecutive cycles is exactly 1 on inc-only updates and 0 on hold.
  - gray_nxt equals gray one cycle later.
  - Feeding gray into the existing gray-to-binary decoder reproduces bin.

Source files
------------

// File: rtl/gray_ptr_counter.sv
// Binary pointer counter with a registered Gray-coded image for clock-domain-crossing pointers.
// The gray and wrap outputs come straight from flops, so they are safe to synchronise into another domain.
module gray_ptr_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             inc,
  input  logic             dir,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_nxt,
  output logic             wrap
);

  localparam int unsigned W = WIDTH;

  logic [W-1:0] bin_n;
  logic         wrap_n;

  // Next-state select, priority clr > load > inc > hold; dir is only looked at when inc=1
  always_comb begin
    bin_n  = bin;
    wrap_n = 1'b0;
    if (clr) begin
      bin_n = '0;
    end else if (load) begin
      bin_n = load_bin;
    end else if (inc) begin
      if (dir) begin
        bin_n  = bin + W'(1);
        wrap_n = &bin;
      end else begin
        bin_n  = bin - W'(1);
        wrap_n = ~|bin;
      end
    end
  end

  assign gray_nxt = bin_n ^ (bin_n >> 1);

  // gray is registered from gray_nxt, never decoded from the registered bin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_n;
      gray <= gray_nxt;
      wrap <= wrap_n;
    end
  end

endmodule
